// File: rtl/psram_responder.sv
// psram_responder: octal-SPI PSRAM target on block RAM, oversampling csn/sclk/data in the clk_i domain.
// Define PSRAM_RESPONDER_STATE_HITS_EN to enable the sticky o_states_hit visit mask.
module psram_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int RD_LATENCY  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       i_csn,
  input  logic       i_sclk,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_data_oe,
  output logic       o_busy,
  output logic       o_cmd_err,
  output logic [2:0] o_state,
  output logic [7:0] o_states_hit
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WDATA  = 3'd3,
    DUMMY  = 3'd4,
    RDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  localparam logic [3:0]  LAT      = 4'(RD_LATENCY);
  localparam logic [10:0] SYNC_RST = {1'b0, 1'b1, 1'b0, 8'h00};

  // The leading valid bit marks samples that really came from the pads since reset.
  logic [10:0] sync [SYNC_STAGES];
  logic vld_s, csn_s, sclk_s, vld_p, csn_p, sclk_p, rise, fall, csn_rise;
  logic [7:0] data_s;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic wr, wr_d, we, we_d, oe_d, err_d;
  logic [ADDR_BITS-1:0] idx, idx_d, widx, widx_d;
  logic [7:0] hi, hi_d, dout_d;
  logic [15:0] wdata, wdata_d, rd_q;
  logic [15:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= SYNC_RST;
      {vld_p, csn_p, sclk_p} <= 3'b010;
    end else begin
      sync[0] <= {1'b1, i_csn, i_sclk, i_data};
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      {vld_p, csn_p, sclk_p} <= {vld_s, csn_s, sclk_s};
    end

  assign {vld_s, csn_s, sclk_s, data_s} = sync[SYNC_STAGES-1];
  assign rise     = vld_p & sclk_s & ~sclk_p;
  assign fall     = vld_p & ~sclk_s & sclk_p;
  assign csn_rise = vld_p & csn_s & ~csn_p;

  always_ff @(posedge clk_i) begin
    if (we) mem[widx] <= wdata;
    rd_q <= mem[idx];
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state     <= IDLE;
      cnt       <= '0;
      wr        <= 1'b0;
      idx       <= '0;
      hi        <= '0;
      we        <= 1'b0;
      widx      <= '0;
      wdata     <= '0;
      o_data    <= '0;
      o_data_oe <= 1'b0;
      o_cmd_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      wr        <= wr_d;
      idx       <= idx_d;
      hi        <= hi_d;
      we        <= we_d;
      widx      <= widx_d;
      wdata     <= wdata_d;
      o_data    <= dout_d;
      o_data_oe <= oe_d;
      o_cmd_err <= err_d;
    end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr_d    = wr;
    idx_d   = idx;
    hi_d    = hi;
    we_d    = 1'b0;
    widx_d  = widx;
    wdata_d = wdata;
    dout_d  = o_data;
    oe_d    = o_data_oe;
    err_d   = 1'b0;
    if (state != IDLE && csn_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state)
        // A low csn on the first real sample means a frame already in flight.
        IDLE: if (vld_s && !csn_s) state_d = (vld_p && csn_p) ? CMD : IGNORE;
        CMD: if (rise) begin
          if (data_s == 8'h02 || data_s == 8'h0B) begin
            state_d = ADDR;
            wr_d    = (data_s == 8'h02);
            cnt_d   = '0;
          end else begin
            state_d = IGNORE;
            err_d   = 1'b1;
          end
        end
        ADDR: if (rise) begin
          idx_d = ADDR_BITS'({idx, data_s});
          cnt_d = cnt + 4'd1;
          if (cnt == 4'd2) begin
            state_d = wr ? WDATA : DUMMY;
            cnt_d   = '0;
          end
        end
        WDATA: if (rise) begin
          if (!cnt[0]) begin
            hi_d  = data_s;
            cnt_d = 4'd1;
          end else begin
            we_d    = 1'b1;
            wdata_d = {hi, data_s};
            widx_d  = idx;
            idx_d   = idx + ADDR_BITS'(1);
            cnt_d   = '0;
          end
        end
        DUMMY: begin
          if (rise) cnt_d = cnt + 4'd1;
          if (fall && cnt == LAT) begin
            dout_d  = rd_q[15:8];
            oe_d    = 1'b1;
            state_d = RDATA;
            cnt_d   = '0;
          end
        end
        // rd_q follows mem[idx], so bumping idx on the low byte prefetches the next word.
        RDATA: if (fall) begin
          if (!cnt[0]) begin
            dout_d = rd_q[7:0];
            idx_d  = idx + ADDR_BITS'(1);
            cnt_d  = 4'd1;
          end else begin
            dout_d = rd_q[15:8];
            cnt_d  = '0;
          end
        end
        IGNORE: state_d = IGNORE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_state = state;

`ifdef PSRAM_RESPONDER_STATE_HITS_EN
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) o_states_hit <= '0;
    else o_states_hit <= o_states_hit | (8'd1 << state);
`else
  assign o_states_hit = 8'h00;
`endif
endmodule
